// File: rtl/mxu_pkg.sv
// Shared types and helpers for the MXU job scheduler: FSM states, operand/result widths.
package mxu_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam int DEF_BIT_WIDTH = 4;
   localparam int DEF_DIM       = 2;

   // Width of one packed DIM x DIM matrix of bw-bit elements.
   function automatic int mat_width(input int bw, input int dim);
      return dim * dim * bw;
   endfunction

   typedef logic [DEF_DIM*DEF_DIM*DEF_BIT_WIDTH-1:0]   mat_a_t;
   typedef logic [DEF_DIM*DEF_DIM*2*DEF_BIT_WIDTH-1:0] mat_c_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
// Zero latency; no state, the pointer is owned by the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      // Scan from the farthest offset down so the nearest requester overwrites last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = ($clog2(NUM_REQ))'(idx);
         end
      end
   end

endmodule

// File: rtl/mxu_job_scheduler.sv
// Round-robin job scheduler in front of one temporal MXU; accept N, start N+1, response one cycle after capture.
// One job in flight; requests are refused until the response handshakes.
module mxu_job_scheduler
   import mxu_pkg::*;
#(
   parameter int BIT_WIDTH = 4,
   parameter int DIM       = 2,
   parameter int NUM_REQ   = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic [NUM_REQ-1:0]                           req_valid,
   output logic [NUM_REQ-1:0]                           req_ready,
   input  logic [NUM_REQ*mat_width(BIT_WIDTH,DIM)-1:0]  req_A,
   input  logic [NUM_REQ*mat_width(BIT_WIDTH,DIM)-1:0]  req_B,
   output logic                                         rsp_valid,
   input  logic                                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]                   rsp_id,
   output logic [mat_width(2*BIT_WIDTH,DIM)-1:0]        rsp_C,
   output logic                                         rsp_timeout,
   output logic                                         busy,
   output logic                                         mxu_start,
   output logic [mat_width(BIT_WIDTH,DIM)-1:0]          mxu_A,
   output logic [mat_width(BIT_WIDTH,DIM)-1:0]          mxu_B,
   input  logic                                         mxu_out_valid,
   input  logic [mat_width(2*BIT_WIDTH,DIM)-1:0]        mxu_out
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int AW = mat_width(BIT_WIDTH, DIM);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [TW-1:0]   wait_cnt;
   logic            accept, capture, expire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (gnt),
      .grant_idx (gnt_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      expire    = 1'b0;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      mxu_start = 1'b0;
      case (state)
         IDLE: begin
            // Gated by reset so a held request cannot see ready while in reset.
            if (reset_n) req_ready = gnt;
            if (|req_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mxu_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A zero count marks the first WAIT cycle, whose valid is stale.
            if (wait_cnt != '0 && mxu_out_valid) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
               expire    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr      <= '0;
         rsp_id      <= '0;
         mxu_A       <= '0;
         mxu_B       <= '0;
         wait_cnt    <= '0;
         rsp_C       <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         if (accept) begin
            mxu_A  <= req_A[gnt_idx*AW +: AW];
            mxu_B  <= req_B[gnt_idx*AW +: AW];
            rsp_id <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
         if (state == ISSUE)
            wait_cnt <= '0;
         else if (state == WAIT && !capture && !expire)
            wait_cnt <= wait_cnt + 1'b1;
         if (capture) begin
            rsp_C       <= mxu_out;
            rsp_timeout <= 1'b0;
         end else if (expire) begin
            rsp_C       <= '0;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mxu_job_scheduler.sv
// Bench for mxu_job_scheduler: MXU stand-in with fixed latency plus a round-robin reference model.
module tb_mxu_job_scheduler;

   localparam int L        = 5;
   localparam int M_NORMAL = 0;
   localparam int M_NEVER  = 1;
   localparam int M_STALE  = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_A, req_B;
   logic        rsp_valid, rsp_ready;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_C;
   logic        rsp_timeout, busy, mxu_start;
   logic [15:0] mxu_A, mxu_B;
   logic        mxu_out_valid;
   logic [31:0] mxu_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ref_ptr = 0;
   int mxu_mode = M_NORMAL;
   int mdl_t = -1;
   logic [15:0] mdl_a, mdl_b;

   mxu_job_scheduler #(.BIT_WIDTH(4), .DIM(2), .NUM_REQ(2), .TIMEOUT(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_B(req_B),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_C(rsp_C),
      .rsp_timeout(rsp_timeout), .busy(busy), .mxu_start(mxu_start),
      .mxu_A(mxu_A), .mxu_B(mxu_B), .mxu_out_valid(mxu_out_valid), .mxu_out(mxu_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Element (i,j) lives at index i*2+j, LSB first.
   function automatic logic [31:0] matmul(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < 2; k++)
               s += int'(a[(i*2+k)*4 +: 4]) * int'(b[(k*2+j)*4 +: 4]);
            c[(i*2+j)*8 +: 8] = 8'(s);
         end
      return c;
   endfunction

   function automatic logic [15:0] rand_mat();
      logic [15:0] m;
      for (int e = 0; e < 4; e++) m[e*4 +: 4] = 4'($urandom_range(0, 11));
      return m;
   endfunction

   function automatic int pick(input logic [1:0] v, input int p);
      for (int k = 0; k < 2; k++)
         if (v[(p + k) % 2]) return (p + k) % 2;
      return -1;
   endfunction

   // MXU stand-in: result L cycles after the start pulse; optional stale pulse one cycle after start.
   always @(negedge clk) begin
      if (!reset_n) begin
         mxu_out_valid = 1'b0;
         mxu_out       = '0;
         mdl_t         = -1;
      end else begin
         if (mxu_start) begin
            mdl_t = 0;
            mdl_a = mxu_A;
            mdl_b = mxu_B;
         end else if (mdl_t >= 0) begin
            mdl_t++;
         end
         mxu_out_valid = 1'b0;
         mxu_out       = '0;
         if (mdl_t == 1 && mxu_mode == M_STALE) begin
            mxu_out_valid = 1'b1;
            mxu_out       = '1;
         end
         if (mdl_t == L && mxu_mode != M_NEVER) begin
            mxu_out_valid = 1'b1;
            mxu_out       = matmul(mdl_a, mdl_b);
            mdl_t         = -1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge+1 with the DUT idle; returns at a negedge+1 the cycle after the handshake.
   task automatic run_job(input logic [1:0] vld, input int mode, input int hold,
                          output int obs_id, output logic [31:0] obs_c);
      int g, t0, n;
      logic [15:0] ea, eb;
      logic [31:0] ec;
      logic eto;
      mxu_mode  = mode;
      req_valid = vld;
      #1;
      g = pick(vld, ref_ptr);
      chk("accept_grant", 64'(req_ready), 64'(1) << g);
      ea      = req_A[g*16 +: 16];
      eb      = req_B[g*16 +: 16];
      ec      = (mode == M_NEVER) ? 32'h0 : matmul(ea, eb);
      eto     = (mode == M_NEVER);
      t0      = cyc;
      ref_ptr = (g + 1) % 2;
      @(negedge clk);
      req_valid[g] = 1'b0;
      req_A[g*16 +: 16] = rand_mat();
      req_B[g*16 +: 16] = rand_mat();
      #1;
      chk("issue", 64'({mxu_start, busy, req_ready, mxu_A, mxu_B}), 64'({1'b1, 1'b1, 2'b00, ea, eb}));
      @(negedge clk);
      #1;
      chk("start_one_cycle", 64'(mxu_start), 64'(0));
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("rsp_arrive", 64'(rsp_valid), 64'(1));
      chk("rsp_latency", 64'(cyc - t0), eto ? 64'(2 + 64) : 64'(2 + L));
      chk("rsp_fields", 64'({rsp_id, rsp_timeout, rsp_C}), 64'({1'(g), eto, ec}));
      chk("operands_held", 64'({mxu_A, mxu_B}), 64'({ea, eb}));
      obs_id = int'(rsp_id);
      obs_c  = rsp_C;
      repeat (hold) begin
         @(negedge clk);
         #1;
         chk("rsp_hold", 64'({rsp_valid, rsp_id, rsp_timeout, req_ready, rsp_C}),
             64'({1'b1, 1'(g), eto, 2'b00, ec}));
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("handshake_cycle", 64'({rsp_valid, req_ready}), 64'({1'b1, 2'b00}));
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("after_handshake", 64'({rsp_valid, busy}), 64'(0));
      if (req_valid != 2'b00)
         chk("next_grant", 64'(req_ready), 64'(1) << pick(req_valid, ref_ptr));
   endtask

   initial begin
      int id0, id1, id2, n;
      logic [31:0] c;
      logic seen;
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      req_A     = {rand_mat(), rand_mat()};
      req_B     = {rand_mat(), rand_mat()};
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_timeout, busy, mxu_start}), 64'(0));
      chk("reset_dat", 64'({rsp_C, mxu_A, mxu_B}), 64'(0));
      @(negedge clk);
      req_valid = 2'b00;
      reset_n   = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_no_req", 64'({req_ready, busy}), 64'(0));

      // Single job, known operands.
      req_A[15:0] = 16'h0321;
      req_B[15:0] = 16'h2022;
      run_job(2'b01, M_NORMAL, 0, id0, c);
      chk("single_id", 64'(id0), 64'(0));
      chk("single_C", 64'(c), 64'(32'h0606_0602));
      run_job(2'b10, M_NORMAL, 0, id0, c);

      // Contention: both held valid for three jobs.
      run_job(2'b11, M_NORMAL, 0, id0, c);
      req_valid = 2'b11;
      run_job(2'b11, M_NORMAL, 0, id1, c);
      run_job(2'b11, M_NORMAL, 0, id2, c);
      chk("contention_order", 64'({id0[1:0], id1[1:0], id2[1:0]}), 64'(6'b00_01_00));

      // Backpressure, timeout and stale valid.
      run_job(2'b11, M_NORMAL, 10, id0, c);
      run_job(2'b01, M_NEVER, 2, id0, c);
      run_job(2'b10, M_STALE, 1, id0, c);

      // Reset in the middle of WAIT.
      mxu_mode  = M_NEVER;
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      req_valid = 2'b11;
      reset_n   = 1'b0;
      #1;
      chk("midjob_reset_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_timeout, busy, mxu_start}), 64'(0));
      chk("midjob_reset_dat", 64'({rsp_C, mxu_A, mxu_B}), 64'(0));
      repeat (2) @(negedge clk);
      req_valid = 2'b00;
      reset_n   = 1'b1;
      ref_ptr   = 0;
      seen      = 1'b0;
      for (n = 0; n < 80; n++) begin
         @(negedge clk);
         #1;
         if (rsp_valid || busy) seen = 1'b1;
      end
      chk("no_rsp_after_reset", 64'(seen), 64'(0));
      run_job(2'b11, M_NORMAL, 0, id0, c);
      chk("ptr_after_reset", 64'(id0), 64'(0));

      // Randomized tail.
      for (int j = 0; j < 8; j++) begin
         logic [1:0] v;
         v = 2'($urandom_range(1, 3));
         run_job(v, ($urandom_range(0, 3) == 0) ? M_STALE : M_NORMAL,
                 int'($urandom_range(0, 3)), id0, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
